// File: rtl/mul_div_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_iter_pkg
// Description : Shared types and helpers for the iterative multiply/divide
//               unit: operation encoding, FSM state enum, default width.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_div_iter_pkg;

    localparam int c_xlen_default = 32;

    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } mdu_state_t;

    // Divide and remainder ops all live in the upper half of the encoding.
    function automatic logic is_div_op(input mdu_op_t op);
        return op[2];
    endfunction

    // rs1 is treated as signed by MUL, MULH, MULHSU, DIV and REM.
    function automatic logic op_src1_signed(input mdu_op_t op);
        return (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    // rs2 is treated as signed by MUL, MULH, DIV and REM.
    function automatic logic op_src2_signed(input mdu_op_t op);
        return (op == MDU_MUL) || (op == MDU_MULH) ||
               (op == MDU_DIV) || (op == MDU_REM);
    endfunction

    // DIV/DIVU return the quotient, REM/REMU the remainder.
    function automatic logic op_returns_quotient(input mdu_op_t op);
        return op[2] & ~op[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_div_step.sv
`default_nettype none
// ============================================================================
// Module      : mdu_div_step
// Description : Combinational restoring-division step retiring DIV_BITS
//               quotient bits. The quotient register carries the not-yet-
//               consumed dividend bits in its MSBs and collects quotient
//               bits in its LSBs.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_div_step #(
    parameter int XLEN     = 32,
    parameter int DIV_BITS = 1
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic [XLEN-1:0] i_quo,
    input  logic [XLEN-1:0] i_divisor,
    output logic [XLEN-1:0] o_rem,
    output logic [XLEN-1:0] o_quo
);

    logic [XLEN:0]   w_trial;
    logic [XLEN-1:0] w_rem;
    logic [XLEN-1:0] w_quo;

    // Shift in one dividend bit, trial-subtract, keep the difference if non-negative.
    always_comb begin
        w_trial = '0;
        w_rem   = i_rem;
        w_quo   = i_quo;
        for (int k = 0; k < DIV_BITS; k++) begin
            w_trial = {w_rem, w_quo[XLEN-1]};
            if (w_trial >= {1'b0, i_divisor}) begin
                w_trial = w_trial - {1'b0, i_divisor};
                w_quo   = {w_quo[XLEN-2:0], 1'b1};
            end else begin
                w_quo   = {w_quo[XLEN-2:0], 1'b0};
            end
            w_rem = w_trial[XLEN-1:0];
        end
        o_rem = w_rem;
        o_quo = w_quo;
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_iter
// Description : Iterative multiply/divide unit for the execute stage.
//               Shift-add multiply (MUL_BITS/cycle) and restoring divide
//               (DIV_BITS/cycle) on operand magnitudes with a final sign
//               fix-up, RV64 word mode, and single-cycle divide special
//               cases. Request is held by the execute stage until o_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_iter
    import mul_div_iter_pkg::*;
#(
    parameter int XLEN     = c_xlen_default,
    parameter int MUL_BITS = 1,
    parameter int DIV_BITS = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_flush,
    input  logic            i_stall,
    input  logic            i_e,
    input  mdu_op_t         i_op,
    input  logic            i_w32,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    output logic            o_valid,
    output logic [XLEN-1:0] o_dest
);

    localparam int         c_dw         = 2 * XLEN;
    localparam logic [6:0] c_mul_last_w = 7'(32 / MUL_BITS - 1);
    localparam logic [6:0] c_mul_last_x = 7'(XLEN / MUL_BITS - 1);
    localparam logic [6:0] c_div_last_w = 7'(32 / DIV_BITS - 1);
    localparam logic [6:0] c_div_last_x = 7'(XLEN / DIV_BITS - 1);

    // Extend a 32-bit value to XLEN, sign- or zero-filled.
    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic s);
        logic [XLEN-1:0] r;
        r       = {XLEN{s & v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    mdu_state_t      r_state;
    mdu_state_t      w_state_next;
    logic            w_accept;

    mdu_op_t         r_op;
    logic            r_w32;
    logic            r_neg;      // product sign, or quotient sign
    logic            r_rem_neg;  // remainder sign (follows dividend)
    logic [c_dw-1:0] r_acc;      // MUL: accumulator; DIV: {remainder, quotient}
    logic [c_dw-1:0] r_opa;      // MUL: multiplicand, shifted left each cycle
    logic [XLEN-1:0] r_opb;      // MUL: multiplier, shifted right; DIV: divisor
    logic [XLEN-1:0] r_dest;
    logic [6:0]      r_cnt;

    // ------------------------------------------------------------------
    // Request decode (only consumed in IDLE)
    // ------------------------------------------------------------------
    logic            w_w32;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_div_req;
    logic [XLEN-1:0] w_a_ext;
    logic [XLEN-1:0] w_b_ext;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_min;
    logic [XLEN-1:0] w_dvd;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_special_res;
    logic [XLEN-1:0] w_div_init;
    logic [6:0]      w_cnt_init;

    // Operand extension, magnitudes and divide special-case detection.
    always_comb begin
        w_w32      = (XLEN == 64) ? i_w32 : 1'b0;
        w_a_signed = op_src1_signed(i_op);
        w_b_signed = op_src2_signed(i_op);
        w_div_req  = is_div_op(i_op);
        w_a_ext    = w_w32 ? ext32(i_src1[31:0], w_a_signed) : i_src1;
        w_b_ext    = w_w32 ? ext32(i_src2[31:0], w_b_signed) : i_src2;
        w_a_neg    = w_a_signed & w_a_ext[XLEN-1];
        w_b_neg    = w_b_signed & w_b_ext[XLEN-1];
        w_a_mag    = w_a_neg ? -w_a_ext : w_a_ext;
        w_b_mag    = w_b_neg ? -w_b_ext : w_b_ext;
        w_min      = w_w32 ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
        w_dvd      = w_w32 ? ext32(i_src1[31:0], 1'b1) : i_src1;
        w_b_zero   = (w_b_ext == '0);
        w_ovf      = w_a_signed & w_b_signed & (w_a_ext == w_min) & (&w_b_ext);
        w_special  = w_div_req & (w_b_zero | w_ovf);
        if (w_b_zero) begin
            w_special_res = op_returns_quotient(i_op) ? {XLEN{1'b1}} : w_dvd;
        end else begin
            w_special_res = op_returns_quotient(i_op) ? w_a_ext : '0;
        end
        // Word-mode dividend starts at the top so its MSB is consumed first.
        w_div_init = w_w32 ? (w_a_mag << (XLEN - 32)) : w_a_mag;
        if (w_div_req) begin
            w_cnt_init = w_w32 ? c_div_last_w : c_div_last_x;
        end else begin
            w_cnt_init = w_w32 ? c_mul_last_w : c_mul_last_x;
        end
    end

    // ------------------------------------------------------------------
    // Multiply step and final fix-up
    // ------------------------------------------------------------------
    logic [c_dw-1:0] w_pp;
    logic [c_dw-1:0] w_acc_sum;
    logic [c_dw-1:0] w_prod;
    logic            w_mul_hi;
    logic [XLEN-1:0] w_mul_res;

    // Partial product of MUL_BITS multiplier bits, negation and half select.
    always_comb begin
        w_pp = '0;
        for (int j = 0; j < MUL_BITS; j++) begin
            if (r_opb[j]) begin
                w_pp = w_pp + (r_opa << j);
            end
        end
        w_acc_sum = r_acc + w_pp;
        w_prod    = r_neg ? -w_acc_sum : w_acc_sum;
        w_mul_hi  = (r_op != MDU_MUL);
        if (r_w32) begin
            w_mul_res = ext32(w_mul_hi ? w_prod[63:32] : w_prod[31:0], 1'b1);
        end else begin
            w_mul_res = w_mul_hi ? w_prod[c_dw-1:XLEN] : w_prod[XLEN-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Divide step and final fix-up
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_step_rem;
    logic [XLEN-1:0] w_step_quo;
    logic [XLEN-1:0] w_quo_fix;
    logic [XLEN-1:0] w_rem_fix;
    logic [XLEN-1:0] w_div_sel;
    logic [XLEN-1:0] w_div_res;

    mdu_div_step #(
        .XLEN     (XLEN),
        .DIV_BITS (DIV_BITS)
    ) u_div_step (
        .i_rem     (r_acc[c_dw-1:XLEN]),
        .i_quo     (r_acc[XLEN-1:0]),
        .i_divisor (r_opb),
        .o_rem     (w_step_rem),
        .o_quo     (w_step_quo)
    );

    // Sign correction of quotient/remainder and result select.
    always_comb begin
        w_quo_fix = r_neg     ? -w_step_quo : w_step_quo;
        w_rem_fix = r_rem_neg ? -w_step_rem : w_step_rem;
        w_div_sel = op_returns_quotient(r_op) ? w_quo_fix : w_rem_fix;
        w_div_res = r_w32 ? ext32(w_div_sel[31:0], 1'b1) : w_div_sel;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, request accept and result handshake; flush overrides all.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        o_valid      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_e && !i_stall) begin
                    w_accept = 1'b1;
                    if (w_special) begin
                        w_state_next = ST_DONE;
                    end else if (w_div_req) begin
                        w_state_next = ST_DIV;
                    end else begin
                        w_state_next = ST_MUL;
                    end
                end
            end
            ST_MUL, ST_DIV: begin
                if (!i_stall && (r_cnt == '0)) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_valid = 1'b1;
                if (!i_stall) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (i_flush) begin
            w_state_next = ST_IDLE;
            w_accept     = 1'b0;
            o_valid      = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // Latch operands on accept, iterate when not stalled, capture the result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_op      <= MDU_MUL;
            r_w32     <= 1'b0;
            r_neg     <= 1'b0;
            r_rem_neg <= 1'b0;
            r_acc     <= '0;
            r_opa     <= '0;
            r_opb     <= '0;
            r_dest    <= '0;
            r_cnt     <= '0;
        end else if (!i_flush) begin
            if (w_accept) begin
                r_op      <= i_op;
                r_w32     <= w_w32;
                r_neg     <= w_a_neg ^ w_b_neg;
                r_rem_neg <= w_a_neg;
                r_opa     <= {{XLEN{1'b0}}, w_a_mag};
                r_opb     <= w_b_mag;
                r_acc     <= w_div_req ? {{XLEN{1'b0}}, w_div_init} : '0;
                r_cnt     <= w_cnt_init;
                if (w_special) begin
                    r_dest <= w_special_res;
                end
            end else if ((r_state == ST_MUL) && !i_stall) begin
                r_acc <= w_acc_sum;
                r_opa <= r_opa << MUL_BITS;
                r_opb <= r_opb >> MUL_BITS;
                if (r_cnt == '0) begin
                    r_dest <= w_mul_res;
                end else begin
                    r_cnt <= r_cnt - 7'd1;
                end
            end else if ((r_state == ST_DIV) && !i_stall) begin
                r_acc <= {w_step_rem, w_step_quo};
                if (r_cnt == '0) begin
                    r_dest <= w_div_res;
                end else begin
                    r_cnt <= r_cnt - 7'd1;
                end
            end
        end
    end

    assign o_dest = r_dest;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_iter
// Description : Self-checking bench for mul_div_iter (XLEN=64, MUL_BITS=1,
//               DIV_BITS=2). A reference model computes result and latency
//               per request; results are queued and compared on o_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_iter;
    import mul_div_iter_pkg::*;

    localparam int c_xlen      = 64;
    localparam int c_mul_bits  = 1;
    localparam int c_div_bits  = 2;
    localparam int c_timeout   = 300;

    typedef struct {
        logic [63:0] res;
        int          lat;
    } exp_t;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_flush;
    logic        i_stall;
    logic        i_e;
    mdu_op_t     i_op;
    logic        i_w32;
    logic [63:0] i_src1;
    logic [63:0] i_src2;
    logic        o_valid;
    logic [63:0] o_dest;

    exp_t        sb_q[$];
    int          n_checks;
    int          n_errors;

    mul_div_iter #(
        .XLEN     (c_xlen),
        .MUL_BITS (c_mul_bits),
        .DIV_BITS (c_div_bits)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_flush (i_flush),
        .i_stall (i_stall),
        .i_e     (i_e),
        .i_op    (i_op),
        .i_w32   (i_w32),
        .i_src1  (i_src1),
        .i_src2  (i_src2),
        .o_valid (o_valid),
        .o_dest  (o_dest)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
        end
    endtask

    // Reference model: native-width arithmetic on extended operands.
    task automatic ref_model(input mdu_op_t op, input logic w32, input logic [63:0] a,
                             input logic [63:0] b, output logic [63:0] res, output int lat);
        logic         sa;
        logic         sb;
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] prod;
        logic [63:0]  xa;
        logic [63:0]  xb;
        logic [63:0]  q;
        logic [63:0]  r;
        logic         special;
        logic         is_div;
        int           w;
        sa = (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_MULHSU) ||
             (op == MDU_DIV) || (op == MDU_REM);
        sb = (op == MDU_MUL) || (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
        w  = w32 ? 32 : 64;
        if (w32) begin
            ea = {{96{sa & a[31]}}, a[31:0]};
            eb = {{96{sb & b[31]}}, b[31:0]};
        end else begin
            ea = {{64{sa & a[63]}}, a};
            eb = {{64{sb & b[63]}}, b};
        end
        xa      = ea[63:0];
        xb      = eb[63:0];
        prod    = ea * eb;
        special = 1'b0;
        is_div  = (op == MDU_DIV) || (op == MDU_DIVU) || (op == MDU_REM) || (op == MDU_REMU);
        q       = '0;
        r       = '0;
        if (!is_div) begin
            if (op == MDU_MUL) res = prod[63:0];
            else               res = w32 ? {32'b0, prod[63:32]} : prod[127:64];
        end else begin
            if (xb == 64'd0) begin
                q = '1; r = xa; special = 1'b1;
            end else if (sa && !w32 && xa == 64'h8000_0000_0000_0000 && xb == '1) begin
                q = xa; r = '0; special = 1'b1;
            end else if (sa && w32 && xa == 64'hFFFF_FFFF_8000_0000 && xb == '1) begin
                q = xa; r = '0; special = 1'b1;
            end else if (sa) begin
                q = $signed(xa) / $signed(xb);
                r = $signed(xa) % $signed(xb);
            end else begin
                q = xa / xb;
                r = xa % xb;
            end
            res = ((op == MDU_DIV) || (op == MDU_DIVU)) ? q : r;
        end
        if (w32) res = {{32{res[31]}}, res[31:0]};
        lat = special ? 1 : ((is_div ? w / c_div_bits : w / c_mul_bits) + 1);
    endtask

    // Present a request in the current IDLE cycle, hold it until o_valid,
    // optionally stall mid-iteration and in DONE. Returns one cycle after consume.
    task automatic run_op(input string tag, input mdu_op_t op, input logic w32,
                          input logic [63:0] a, input logic [63:0] b,
                          input int stall_at, input int stall_len, input int hold);
        exp_t e;
        int   cyc;
        logic got;
        ref_model(op, w32, a, b, e.res, e.lat);
        e.lat = e.lat + stall_len;
        sb_q.push_back(e);
        i_e    = 1'b1;
        i_op   = op;
        i_w32  = w32;
        i_src1 = a;
        i_src2 = b;
        check({tag, ":valid_c0"}, 64'(o_valid), 64'd0);
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < c_timeout) begin
            @(negedge i_clk);
            cyc++;
            if (o_valid) got = 1'b1;
            else i_stall = (stall_len > 0) && (cyc >= stall_at) && (cyc < stall_at + stall_len);
        end
        i_e     = 1'b0;
        i_stall = 1'b0;
        e = sb_q.pop_front();
        check({tag, ":valid"}, 64'(got), 64'd1);
        check({tag, ":latency"}, 64'(cyc), 64'(e.lat));
        check({tag, ":dest"}, o_dest, e.res);
        for (int h = 0; h < hold; h++) begin
            i_stall = 1'b1;
            @(negedge i_clk);
            check({tag, ":hold_valid"}, 64'(o_valid), 64'd1);
            check({tag, ":hold_dest"}, o_dest, e.res);
        end
        i_stall = 1'b0;
        @(negedge i_clk);
        check({tag, ":consumed"}, 64'(o_valid), 64'd0);
    endtask

    initial begin
        mdu_op_t     rop;
        logic        rw;
        logic [63:0] ra;
        logic [63:0] rb;
        n_checks = 0;
        n_errors = 0;
        i_rst_n  = 1'b0;
        i_flush  = 1'b0;
        i_stall  = 1'b0;
        i_e      = 1'b0;
        i_op     = MDU_MUL;
        i_w32    = 1'b0;
        i_src1   = '0;
        i_src2   = '0;
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        check("reset_valid", 64'(o_valid), 64'd0);
        check("reset_dest", o_dest, 64'd0);

        // Directed vectors (word mode gives the 32-bit behaviour)
        run_op("mulw_neg",   MDU_MUL,   1'b1, 64'h0000_0000_0000_0007, 64'h0000_0000_FFFF_FFFD, 0, 0, 0);
        run_op("mulh_min",   MDU_MULH,  1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 0, 0, 0);
        run_op("mulhu_max",  MDU_MULHU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 0, 0, 0);
        run_op("divw_zero",  MDU_DIV,   1'b1, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_0000, 0, 0, 0);
        run_op("remuw_zero", MDU_REMU,  1'b1, 64'h0000_0000_0000_1234, 64'h0000_0000_0000_0000, 0, 0, 0);
        run_op("divw_ovf",   MDU_DIV,   1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 0, 0, 0);
        run_op("div_zero",   MDU_DIV,   1'b0, 64'h0000_0000_0000_1234, 64'h0, 0, 0, 0);
        run_op("rem_ovf",    MDU_REM,   1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        run_op("divw_m7",    MDU_DIV,   1'b1, 64'h0000_0001_FFFF_FFF9, 64'h2, 0, 0, 0);
        run_op("remw_m7",    MDU_REM,   1'b1, 64'h0000_0001_FFFF_FFF9, 64'h2, 0, 0, 0);
        run_op("divw_stall", MDU_DIV,   1'b1, 64'd100, 64'd7, 5, 5, 0);
        run_op("divw_hold",  MDU_DIV,   1'b1, 64'd100, 64'd7, 0, 0, 3);
        run_op("mul64",      MDU_MUL,   1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h0000_0001_0000_0003, 0, 0, 0);
        run_op("mulhsu64",   MDU_MULHSU,1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0);
        run_op("divu64",     MDU_DIVU,  1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0003, 0, 0, 0);
        run_op("rem64",      MDU_REM,   1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'h0000_0000_0000_0007, 0, 0, 0);

        // Random operations across all ops and both widths
        for (int n = 0; n < 24; n++) begin
            rop = mdu_op_t'($urandom_range(0, 7));
            rw  = 1'($urandom_range(0, 1));
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) rb = '0;
            else if ($urandom_range(0, 3) == 0) rb = 64'($urandom_range(1, 15));
            run_op("random", rop, rw, ra, rb, 0, 0, 0);
        end

        // Flush in cycle 10 of a divide, then a multiply the next cycle
        i_e    = 1'b1;
        i_op   = MDU_DIV;
        i_w32  = 1'b1;
        i_src1 = 64'd1000;
        i_src2 = 64'd3;
        for (int c = 1; c <= 10; c++) @(negedge i_clk);
        check("flush_busy", 64'(o_valid), 64'd0);
        i_flush = 1'b1;
        i_e     = 1'b0;
        @(negedge i_clk);
        i_flush = 1'b0;
        check("flush_idle", 64'(o_valid), 64'd0);
        run_op("after_flush", MDU_MUL, 1'b1, 64'd3, 64'd5, 0, 0, 0);

        // Asynchronous reset mid-multiply clears outputs without a clock edge
        i_e    = 1'b1;
        i_op   = MDU_MUL;
        i_w32  = 1'b0;
        i_src1 = 64'h1234_5678_9ABC_DEF0;
        i_src2 = 64'h0FED_CBA9_8765_4321;
        repeat (10) @(negedge i_clk);
        #2 i_rst_n = 1'b0;
        #1;
        check("areset_valid", 64'(o_valid), 64'd0);
        check("areset_dest", o_dest, 64'd0);
        i_e = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("post_reset_valid", 64'(o_valid), 64'd0);
        run_op("post_reset", MDU_MULHU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0010, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mul_div_iter.md
# mul_div_iter

Parametrised iterative multiply/divide functional unit for the execute stage. It replaces the fixed-width MDU with one that is configurable in XLEN and in radix (bits retired per cycle). It adds RV64 word-mode (`*W`) operation and early-out on division special cases. It keeps the execute-stage stall handshake: the execute stage holds the request and stalls until `o_valid`.

## Interface
Parameters:
- XLEN, 32 — datapath width; 32 or 64.
- MUL_BITS, 1 — multiplier bits retired per cycle; 1, 2 or 4; must divide 32.
- DIV_BITS, 1 — quotient bits retired per cycle; 1 or 2; must divide 32.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low; one clock.
- i_flush  in  1  pipeline flush; synchronous abort to IDLE.
- i_stall  in  1  downstream stall; freezes FSM progress and the handshake.
- i_e  in  1  request enable; held with stable operands until accepted.
- i_op  in  3  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (`mdu_op_t`).
- i_w32  in  1  word mode; legal only when XLEN=64, ignored when XLEN=32.
- i_src1  in  XLEN  rs1 operand.
- i_src2  in  XLEN  rs2 operand.
- o_valid  out  1  result ready; high only in state DONE.
- o_dest  out  XLEN  result; stable while o_valid is high.

## Operation
- Effective width W = 32 if (i_w32 & XLEN==64), else XLEN.
- In word mode, operands are the low 32 bits, sign- or zero-extended per op. The 32-bit result is sign-extended to XLEN.
- FSM states are IDLE, MUL, DIV, DONE.
- IDLE:
  - A request (i_e & ~i_stall) latches op, w32, |a|, |b| and the result sign.
  - MUL ops go to MUL. DIV/REM ops go to DIV.
  - Divide by zero goes directly to DONE: quotient = all ones, remainder = dividend.
  - Signed overflow (min_int / -1) goes directly to DONE: quotient = dividend, remainder = 0.
- MUL: shift-add of MUL_BITS per cycle into a 2W-bit accumulator.
  - Runs W/MUL_BITS cycles.
  - The final cycle applies two's-complement negation if required and selects the low half (MUL) or high half (MULH*). It then enters DONE.
- DIV: restoring division, DIV_BITS per cycle, W/DIV_BITS cycles.
  - The final cycle applies sign correction: quotient sign = sa^sb, remainder sign = sa. It then enters DONE.
- DONE:
  - o_valid=1.
  - If ~i_stall, the result is consumed and the next state is IDLE.
  - If i_stall, hold DONE and o_dest.
- i_stall in MUL/DIV freezes the iteration counter and accumulators.
- i_flush in any state: next state IDLE, o_valid=0, the in-flight result is discarded. i_flush has priority over i_stall and over a new request.
- If i_e drops while in MUL/DIV/DONE, the operation completes to DONE, and the result is consumed or flushed as normal.
- Reset:
  - State = IDLE, o_valid = 0, o_dest = 0, counters = 0.
  - Assertion mid-operation aborts immediately and asynchronously.

## Timing
- Request accepted in cycle 0 (IDLE). o_valid is never high in cycle 0.
- MUL: o_valid first high in cycle W/MUL_BITS + 1. Examples: XLEN=32, MUL_BITS=1 → cycle 33; MUL_BITS=4 → cycle 9.
- DIV: o_valid first high in cycle W/DIV_BITS + 1. Examples: XLEN=64, w32, DIV_BITS=2 → cycle 17.
- Division special cases: o_valid high in cycle 1.
- Each stalled cycle adds exactly one cycle of latency.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE is consumed. There are no bubbles beyond that.
- o_dest is registered. No combinational path exists from i_src* to o_dest or o_valid.

## Structure
- Shared package (`include/instr.svh` / config):
  - `mdu_op_t` encoding.
  - XLEN default.
  - FSM state enum `mdu_state_t`.
- One sub-module, `mdu_div_step`: a combinational DIV_BITS-wide restoring step (remainder, quotient in → out), instantiated once.
- The multiplier step stays inline.

## Test plan
- XLEN=32, MUL_BITS=1, MUL 0x0000_0007 × 0xFFFF_FFFD → o_valid at cycle 33, o_dest=0xFFFF_FFEB.
- XLEN=32, MULH 0x8000_0000 × 0x8000_0000 → 0x4000_0000. MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE.
- DIV by zero: DIV 0x1234 / 0 → 0xFFFF_FFFF, and REMU 0x1234 / 0 → 0x1234, each with o_valid at cycle 1. DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000.
- XLEN=64, DIV_BITS=2, w32 DIVW src1=0x0000_0001_FFFF_FFF9 (low 32 = -7), src2=2 → 0xFFFF_FFFF_FFFF_FFFD at cycle 17. REMW of the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- DIV 100/7 with i_stall high for 5 cycles mid-iteration → result 14 delivered exactly 5 cycles late. i_stall high in DONE → o_valid and o_dest held until release.
- i_flush at cycle 10 of a DIV, then a new MUL 3×5 next cycle → no stale o_valid, and 15 is returned at the nominal latency. Async i_rst_n pulse mid-MUL → o_valid=0, o_dest=0 immediately.
